// File: rtl/grey_decade_chain_if.sv
// Bundled count/load/result signals for the multi-digit decade code counter.
// The optional o_bcd member is present only when GREY_BCD_OUT_EN is defined.
interface grey_decade_chain_if #(
  parameter int pDIGITS = 2
);
  logic                   i_cnt;
  logic                   i_dir;
  logic                   i_load;
  logic [4*pDIGITS-1:0]   i_load_val;
  logic [5*pDIGITS-1:0]   o_cnt;
  logic                   o_roll;
  logic                   o_err;
`ifdef GREY_BCD_OUT_EN
  logic [4*pDIGITS-1:0]   o_bcd;
`endif

  modport master (
    output i_cnt, i_dir, i_load, i_load_val,
`ifdef GREY_BCD_OUT_EN
    input  o_bcd,
`endif
    input  o_cnt, o_roll, o_err
  );

  modport slave (
    input  i_cnt, i_dir, i_load, i_load_val,
`ifdef GREY_BCD_OUT_EN
    output o_bcd,
`endif
    output o_cnt, o_roll, o_err
  );
endinterface

// File: rtl/grey_decade_chain.sv
// Multi-digit up/down decade counter using 5-bit single-bit-change digit codes; one-edge update.
// Define GREY_BCD_OUT_EN to add the registered o_bcd output alongside o_cnt.
module grey_decade_chain #(
  parameter int pDIGITS = 2,
  parameter int pINIT   = 0,
  parameter int pSYNC   = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  grey_decade_chain_if.slave  bus
);

  function automatic logic [4:0] enc(input logic [3:0] v);
    case (v)
      4'd0:    enc = 5'b11000;
      4'd1:    enc = 5'b11001;
      4'd2:    enc = 5'b10001;
      4'd3:    enc = 5'b10011;
      4'd4:    enc = 5'b00011;
      4'd5:    enc = 5'b00111;
      4'd6:    enc = 5'b00110;
      4'd7:    enc = 5'b01110;
      4'd8:    enc = 5'b01100;
      4'd9:    enc = 5'b11100;
      default: enc = 5'b11000;
    endcase
  endfunction

  // 4'hF marks a code outside the table.
  function automatic logic [3:0] dec(input logic [4:0] c);
    case (c)
      5'b11000: dec = 4'd0;
      5'b11001: dec = 4'd1;
      5'b10001: dec = 4'd2;
      5'b10011: dec = 4'd3;
      5'b00011: dec = 4'd4;
      5'b00111: dec = 4'd5;
      5'b00110: dec = 4'd6;
      5'b01110: dec = 4'd7;
      5'b01100: dec = 4'd8;
      5'b11100: dec = 4'd9;
      default:  dec = 4'hF;
    endcase
  endfunction

  function automatic logic [5*pDIGITS-1:0] init_code();
    logic [5*pDIGITS-1:0] r;
    int n;
    r = '0;
    n = pINIT;
    for (int k = 0; k < pDIGITS; k++) begin
      r[5*k +: 5] = enc(4'(n % 10));
      n = n / 10;
    end
    return r;
  endfunction

  localparam logic [5*pDIGITS-1:0] INIT_CODE = init_code();

  logic                  ev;
  logic [5*pDIGITS-1:0]  cnt_q, cnt_d, cur_cnt;
  logic                  roll_q, roll_d;
  logic                  err_q, err_d;
  logic [3:0]            v;
  logic [3:0]            nib;
  logic                  step;

  generate
    if (pSYNC != 0) begin : g_sync
      // Flops reset high so a level held across reset is not seen as a rising edge.
      logic [2:0] sync_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= 3'b111;
        else          sync_q <= {sync_q[1:0], bus.i_cnt};
      end
      assign ev = sync_q[1] & ~sync_q[2];
    end else begin : g_strobe
      assign ev = bus.i_cnt;
    end
  endgenerate

  assign cur_cnt = cnt_q;

  always_comb begin
    cnt_d  = cur_cnt;
    roll_d = 1'b0;
    err_d  = err_q;
    v      = 4'd0;
    nib    = 4'd0;
    step   = 1'b1;
    if (bus.i_load) begin
      err_d = 1'b0;
      for (int k = 0; k < pDIGITS; k++) begin
        nib = bus.i_load_val[4*k +: 4];
        cnt_d[5*k +: 5] = enc((nib > 4'd9) ? 4'd0 : nib);
      end
    end else if (ev) begin
      // step carries the "all lower digits at the wrap boundary" condition upward.
      for (int k = 0; k < pDIGITS; k++) begin
        v = dec(cur_cnt[5*k +: 5]);
        if (v == 4'hF) begin
          cnt_d[5*k +: 5] = enc(4'd0);
          err_d = 1'b1;
          step  = 1'b0;
        end else begin
          if (step) begin
            if (bus.i_dir) cnt_d[5*k +: 5] = enc((v == 4'd9) ? 4'd0 : v + 4'd1);
            else           cnt_d[5*k +: 5] = enc((v == 4'd0) ? 4'd9 : v - 4'd1);
          end
          step = step & (v == (bus.i_dir ? 4'd9 : 4'd0));
        end
      end
      roll_d = step;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= INIT_CODE;
      roll_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      roll_q <= roll_d;
      err_q  <= err_d;
    end
  end

  assign bus.o_cnt  = cnt_q;
  assign bus.o_roll = roll_q;
  assign bus.o_err  = err_q;

`ifdef GREY_BCD_OUT_EN
  function automatic logic [4*pDIGITS-1:0] to_bcd(input logic [5*pDIGITS-1:0] c);
    logic [4*pDIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < pDIGITS; k++) r[4*k +: 4] = dec(c[5*k +: 5]);
    return r;
  endfunction

  localparam logic [4*pDIGITS-1:0] INIT_BCD = to_bcd(INIT_CODE);

  logic [4*pDIGITS-1:0] bcd_q, bcd_d;

  assign bcd_d = to_bcd(cnt_d);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) bcd_q <= INIT_BCD;
    else          bcd_q <= bcd_d;
  end

  assign bus.o_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_grey_decade_chain.sv
// Directed bench: a strobe-mode counter (pINIT=98) and a synchronised-input counter (pINIT=0).
module tb_grey_decade_chain;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  grey_decade_chain_if #(.pDIGITS(2)) if0();
  grey_decade_chain_if #(.pDIGITS(2)) if1();

  grey_decade_chain #(.pDIGITS(2), .pINIT(98), .pSYNC(0)) u_dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if0)
  );

  grey_decade_chain #(.pDIGITS(2), .pINIT(0), .pSYNC(1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if1)
  );

  function automatic logic [4:0] gc(input int d);
    case (d)
      0: gc = 5'b11000;
      1: gc = 5'b11001;
      2: gc = 5'b10001;
      3: gc = 5'b10011;
      4: gc = 5'b00011;
      5: gc = 5'b00111;
      6: gc = 5'b00110;
      7: gc = 5'b01110;
      8: gc = 5'b01100;
      9: gc = 5'b11100;
      default: gc = 5'b00000;
    endcase
  endfunction

  function automatic logic [9:0] c2(input int n);
    return {gc(n / 10), gc(n % 10)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.i_cnt = 1'b0; if0.i_dir = 1'b1; if0.i_load = 1'b0; if0.i_load_val = 8'h00;
    if1.i_cnt = 1'b0; if1.i_dir = 1'b1; if1.i_load = 1'b0; if1.i_load_val = 8'h00;
    #12;
    vecs++; if (if0.o_cnt !== c2(98)) begin errs++; $display("FAIL rst_cnt0 got %b want %b", if0.o_cnt, c2(98)); end
    vecs++; if (if0.o_roll !== 1'b0) begin errs++; $display("FAIL rst_roll0 got %b want 0", if0.o_roll); end
    vecs++; if (if0.o_err !== 1'b0) begin errs++; $display("FAIL rst_err0 got %b want 0", if0.o_err); end
    vecs++; if (if1.o_cnt !== c2(0)) begin errs++; $display("FAIL rst_cnt1 got %b want %b", if1.o_cnt, c2(0)); end
`ifdef GREY_BCD_OUT_EN
    vecs++; if (if0.o_bcd !== 8'h98) begin errs++; $display("FAIL rst_bcd0 got %h want 98", if0.o_bcd); end
`endif
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    if0.i_cnt = 1'b1; if0.i_dir = 1'b1;
    cyc();
    vecs++; if (if0.o_cnt !== c2(99)) begin errs++; $display("FAIL up1_cnt got %b want %b", if0.o_cnt, c2(99)); end
    vecs++; if (if0.o_roll !== 1'b0) begin errs++; $display("FAIL up1_roll got %b want 0", if0.o_roll); end
    cyc();
    vecs++; if (if0.o_cnt !== c2(0)) begin errs++; $display("FAIL up2_cnt got %b want %b", if0.o_cnt, c2(0)); end
    vecs++; if (if0.o_roll !== 1'b1) begin errs++; $display("FAIL up2_roll got %b want 1", if0.o_roll); end
    if0.i_cnt = 1'b0;
    cyc();
    vecs++; if (if0.o_cnt !== c2(0)) begin errs++; $display("FAIL up_hold_cnt got %b want %b", if0.o_cnt, c2(0)); end
    vecs++; if (if0.o_roll !== 1'b0) begin errs++; $display("FAIL up_hold_roll got %b want 0", if0.o_roll); end
  endtask

  task automatic test_carry_borrow();
    if0.i_load = 1'b1; if0.i_load_val = 8'h19;
    cyc();
    if0.i_load = 1'b0; if0.i_cnt = 1'b1; if0.i_dir = 1'b1;
    cyc();
    vecs++; if (if0.o_cnt !== c2(20)) begin errs++; $display("FAIL carry_cnt got %b want %b", if0.o_cnt, c2(20)); end
    if0.i_dir = 1'b0;
    cyc();
    vecs++; if (if0.o_cnt !== c2(19)) begin errs++; $display("FAIL borrow_cnt got %b want %b", if0.o_cnt, c2(19)); end
    if0.i_cnt = 1'b0; if0.i_dir = 1'b1;
    cyc();
    if0.i_cnt = 1'b1; if0.i_dir = 1'b0;
    cyc();
    vecs++; if (if0.o_cnt !== c2(18)) begin errs++; $display("FAIL dir_at_event got %b want %b", if0.o_cnt, c2(18)); end
    if0.i_cnt = 1'b0;
  endtask

  task automatic test_count_down_load();
    if0.i_load = 1'b1; if0.i_load_val = 8'h00;
    cyc();
    vecs++; if (if0.o_cnt !== c2(0)) begin errs++; $display("FAIL load00_cnt got %b want %b", if0.o_cnt, c2(0)); end
    if0.i_load = 1'b0; if0.i_cnt = 1'b1; if0.i_dir = 1'b0;
    cyc();
    vecs++; if (if0.o_cnt !== 10'b11100_11100) begin errs++; $display("FAIL dn_cnt got %b want 1110011100", if0.o_cnt); end
    vecs++; if (if0.o_roll !== 1'b1) begin errs++; $display("FAIL dn_roll got %b want 1", if0.o_roll); end
    if0.i_load = 1'b1; if0.i_load_val = 8'h47;
    cyc();
    vecs++; if (if0.o_cnt !== c2(47)) begin errs++; $display("FAIL ldpri_cnt got %b want %b", if0.o_cnt, c2(47)); end
    vecs++; if (if0.o_roll !== 1'b0) begin errs++; $display("FAIL ldpri_roll got %b want 0", if0.o_roll); end
`ifdef GREY_BCD_OUT_EN
    vecs++; if (if0.o_bcd !== 8'h47) begin errs++; $display("FAIL ldpri_bcd got %h want 47", if0.o_bcd); end
`endif
    if0.i_cnt = 1'b0; if0.i_load_val = 8'hA3;
    cyc();
    vecs++; if (if0.o_cnt !== c2(3)) begin errs++; $display("FAIL ldA3_cnt got %b want %b", if0.o_cnt, c2(3)); end
    if0.i_load = 1'b0;
  endtask

  task automatic test_illegal();
    if0.i_load = 1'b1; if0.i_load_val = 8'h42;
    cyc();
    if0.i_load = 1'b0;
    vecs++; if (if0.o_cnt !== c2(42)) begin errs++; $display("FAIL ill_pre_cnt got %b want %b", if0.o_cnt, c2(42)); end
    force u_dut0.cur_cnt = 10'b00011_10101;
    if0.i_cnt = 1'b1; if0.i_dir = 1'b1;
    cyc();
    release u_dut0.cur_cnt;
    if0.i_cnt = 1'b0;
    vecs++; if (if0.o_cnt !== c2(40)) begin errs++; $display("FAIL ill_cnt got %b want %b", if0.o_cnt, c2(40)); end
    vecs++; if (if0.o_err !== 1'b1) begin errs++; $display("FAIL ill_err got %b want 1", if0.o_err); end
    if0.i_cnt = 1'b1;
    cyc();
    if0.i_cnt = 1'b0;
    cyc();
    vecs++; if (if0.o_cnt !== c2(41)) begin errs++; $display("FAIL ill_next_cnt got %b want %b", if0.o_cnt, c2(41)); end
    vecs++; if (if0.o_err !== 1'b1) begin errs++; $display("FAIL ill_sticky got %b want 1", if0.o_err); end
    if0.i_load = 1'b1; if0.i_load_val = 8'h42;
    cyc();
    if0.i_load = 1'b0;
    vecs++; if (if0.o_err !== 1'b0) begin errs++; $display("FAIL ill_clr got %b want 0", if0.o_err); end
  endtask

  task automatic test_sync();
    vecs++; if (if1.o_cnt !== c2(0)) begin errs++; $display("FAIL sync_idle got %b want %b", if1.o_cnt, c2(0)); end
    if1.i_cnt = 1'b0; if1.i_dir = 1'b1;
    cyc(); cyc();
    if1.i_cnt = 1'b1;
    cyc();
    vecs++; if (if1.o_cnt !== c2(0)) begin errs++; $display("FAIL sync_e1 got %b want %b", if1.o_cnt, c2(0)); end
    cyc();
    vecs++; if (if1.o_cnt !== c2(0)) begin errs++; $display("FAIL sync_e2 got %b want %b", if1.o_cnt, c2(0)); end
    cyc();
    vecs++; if (if1.o_cnt !== c2(1)) begin errs++; $display("FAIL sync_e3 got %b want %b", if1.o_cnt, c2(1)); end
    for (int i = 0; i < 7; i++) begin
      cyc();
      vecs++; if (if1.o_cnt !== c2(1)) begin errs++; $display("FAIL sync_held%0d got %b want %b", i, if1.o_cnt, c2(1)); end
    end
  endtask

  task automatic test_reset_midcount();
    if1.i_cnt = 1'b0;
    cyc(); cyc(); cyc();
    if1.i_cnt = 1'b1;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    vecs++; if (if1.o_cnt !== c2(0)) begin errs++; $display("FAIL arst_cnt1 got %b want %b", if1.o_cnt, c2(0)); end
    vecs++; if (if0.o_cnt !== c2(98)) begin errs++; $display("FAIL arst_cnt0 got %b want %b", if0.o_cnt, c2(98)); end
    cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      vecs++; if (if1.o_cnt !== c2(0)) begin errs++; $display("FAIL post_rst%0d got %b want %b", i, if1.o_cnt, c2(0)); end
    end
    vecs++; if (if0.o_cnt !== c2(98)) begin errs++; $display("FAIL post_rst_cnt0 got %b want %b", if0.o_cnt, c2(98)); end
    vecs++; if (if0.o_err !== 1'b0) begin errs++; $display("FAIL post_rst_err0 got %b want 0", if0.o_err); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_carry_borrow();
    test_count_down_load();
    test_illegal();
    test_sync();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
